// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern generator with built-in step prescaler.
// Patterns: fill, drain, chase, fill-then-drain; direction selectable.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             done
);

    typedef enum logic {FILL, DRAIN} phase_t;

    localparam logic [1:0]       MODE_FILL  = 2'b00;
    localparam logic [1:0]       MODE_DRAIN = 2'b01;
    localparam logic [1:0]       MODE_CHASE = 2'b10;
    localparam logic [WIDTH-1:0] ONES       = '1;
    localparam logic [WIDTH-1:0] LSB_HOT    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_HOT    = LSB_HOT << (WIDTH - 1);
    localparam logic [DIV_W-1:0] CNT_MAX    = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] q_n, start_hot;
    logic [1:0]       mode_q, mode_q_n;
    phase_t           phase, phase_n;
    logic             tick_n, done_n;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                  input logic d, input logic b);
        return d ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v, input logic d);
        return d ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    assign start_hot = dir ? MSB_HOT : LSB_HOT;

    always_comb begin
        cnt_n    = cnt;
        q_n      = q;
        phase_n  = phase;
        mode_q_n = mode_q;
        tick_n   = 1'b0;
        done_n   = 1'b0;
        if (mode != mode_q) begin
            // A mode change restarts the sequence and overrides any pending step
            mode_q_n = mode;
            cnt_n    = '0;
            phase_n  = FILL;
            case (mode)
                MODE_DRAIN: q_n = ONES;
                MODE_CHASE: q_n = start_hot;
                default:    q_n = '0;
            endcase
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt_n  = '0;
                tick_n = 1'b1;
                case (mode_q)
                    MODE_FILL: begin
                        if (q == ONES) begin
                            q_n    = '0;
                            done_n = 1'b1;
                        end else begin
                            q_n = shift_in(q, dir, 1'b1);
                        end
                    end
                    MODE_DRAIN: begin
                        if (q == '0) begin
                            q_n    = ONES;
                            done_n = 1'b1;
                        end else begin
                            q_n = shift_in(q, dir, 1'b0);
                        end
                    end
                    MODE_CHASE: begin
                        if ($onehot(q)) begin
                            q_n    = rotate(q, dir);
                            done_n = dir ? q[0] : q[WIDTH-1];
                        end else begin
                            q_n = start_hot;
                        end
                    end
                    default: begin
                        if (phase == FILL) begin
                            q_n = shift_in(q, dir, 1'b1);
                            if (q_n == ONES) phase_n = DRAIN;
                        end else begin
                            q_n = shift_in(q, dir, 1'b0);
                            if (q_n == '0) begin
                                phase_n = FILL;
                                done_n  = 1'b1;
                            end
                        end
                    end
                endcase
            end else begin
                cnt_n = cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            cnt    <= '0;
            q      <= '0;
            phase  <= FILL;
            mode_q <= MODE_FILL;
            tick   <= 1'b0;
            done   <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            q      <= q_n;
            phase  <= phase_n;
            mode_q <= mode_q_n;
            tick   <= tick_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed literal sequences plus randomized
// stimulus checked every cycle against a behavioural model (two instances).
module tb_led_pattern_gen;

    logic       clk, rs, en, dir;
    logic [1:0] mode;
    logic [3:0] q0;
    logic [5:0] q1;
    logic       tick0, done0, tick1, done1;

    int vectors = 0;
    int miscompares = 0;
    bit started = 0;

    int m_q[2], m_cnt[2], m_ph[2], m_mq[2], m_tick[2], m_done[2];
    int exp_seq[8];

    led_pattern_gen #(.WIDTH(4), .DIV(3), .DIV_W(2)) dut0 (
        .clk(clk), .rs(rs), .en(en), .mode(mode), .dir(dir),
        .q(q0), .tick(tick0), .done(done0)
    );

    led_pattern_gen #(.WIDTH(6), .DIV(1), .DIV_W(1)) dut1 (
        .clk(clk), .rs(rs), .en(en), .mode(mode), .dir(dir),
        .q(q1), .tick(tick1), .done(done1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int shin(input int v, input int b, input int w, input bit d);
        return d ? ((v >> 1) | (b << (w - 1))) : (((v << 1) | b) & ((1 << w) - 1));
    endfunction

    // Reference: one clock edge of the pattern generator, in plain integers
    task automatic model_edge(input int i);
        int w     = (i == 0) ? 4 : 6;
        int dv    = (i == 0) ? 3 : 1;
        int mask  = (1 << w) - 1;
        int start = dir ? (1 << (w - 1)) : 1;
        int far   = dir ? 1 : (1 << (w - 1));
        if (!rs) begin
            m_q[i] = 0; m_cnt[i] = 0; m_ph[i] = 0; m_mq[i] = 0; m_tick[i] = 0; m_done[i] = 0;
        end else if (int'(mode) != m_mq[i]) begin
            m_mq[i] = int'(mode); m_cnt[i] = 0; m_ph[i] = 0; m_tick[i] = 0; m_done[i] = 0;
            m_q[i] = (mode == 2'd1) ? mask : (mode == 2'd2) ? start : 0;
        end else if (!en) begin
            m_tick[i] = 0; m_done[i] = 0;
        end else if (m_cnt[i] == dv - 1) begin
            m_cnt[i] = 0; m_tick[i] = 1; m_done[i] = 0;
            case (m_mq[i])
                0: if (m_q[i] == mask) begin m_q[i] = 0; m_done[i] = 1; end
                   else m_q[i] = shin(m_q[i], 1, w, dir);
                1: if (m_q[i] == 0) begin m_q[i] = mask; m_done[i] = 1; end
                   else m_q[i] = shin(m_q[i], 0, w, dir);
                2: if ($countones(m_q[i]) == 1) begin
                       m_done[i] = (m_q[i] == far);
                       m_q[i] = dir ? ((m_q[i] >> 1) | ((m_q[i] & 1) << (w - 1)))
                                    : (((m_q[i] << 1) | (m_q[i] >> (w - 1))) & mask);
                   end else m_q[i] = start;
                default: if (m_ph[i] == 0) begin
                       m_q[i] = shin(m_q[i], 1, w, dir);
                       if (m_q[i] == mask) m_ph[i] = 1;
                   end else begin
                       m_q[i] = shin(m_q[i], 0, w, dir);
                       if (m_q[i] == 0) begin m_ph[i] = 0; m_done[i] = 1; end
                   end
            endcase
        end else begin
            m_cnt[i]++; m_tick[i] = 0; m_done[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_q0", int'(q0), m_q[0]);
            chk("model_tick0", int'(tick0), m_tick[0]);
            chk("model_done0", int'(done0), m_done[0]);
            chk("model_q1", int'(q1), m_q[1]);
            chk("model_tick1", int'(tick1), m_tick[1]);
            chk("model_done1", int'(done1), m_done[1]);
        end
    end

    task automatic do_reset();
        rs = 0;
        en = 0;
        @(negedge clk);
        rs = 1;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!tick0 && cyc < 20);
        if (!tick0) chk("tick_timeout", 0, 1);
    endtask

    task automatic run_seq(input string nm, input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            wait_tick(c);
            chk({nm, "_spacing"}, c, 3);
            chk({nm, "_q"}, int'(q0), exp_seq[k]);
            chk({nm, "_done"}, int'(done0), (k == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int c;
        rs = 0; en = 0; mode = 2'd0; dir = 0;
        @(negedge clk);
        started = 1;
        chk("reset_q", int'(q0), 0);
        chk("reset_tick", int'(tick0), 0);
        chk("reset_done", int'(done0), 0);

        // fill, dir=0
        mode = 2'd0; dir = 0; do_reset(); en = 1;
        exp_seq[0:4] = '{1, 3, 7, 15, 0};
        run_seq("fill", 5);

        // drain from reset: reload on the first cycle
        mode = 2'd1; dir = 0; do_reset(); en = 1;
        @(negedge clk);
        chk("drain_reload_q", int'(q0), 15);
        chk("drain_reload_tick", int'(tick0), 0);
        exp_seq[0:4] = '{14, 12, 8, 0, 15};
        run_seq("drain", 5);

        // chase, dir=1
        mode = 2'd2; dir = 1; do_reset(); en = 1;
        @(negedge clk);
        chk("chase_reload_q", int'(q0), 8);
        exp_seq[0:3] = '{4, 2, 1, 8};
        run_seq("chase", 4);

        // fill-then-drain, dir=0
        mode = 2'd3; dir = 0; do_reset(); en = 1;
        @(negedge clk);
        exp_seq = '{1, 3, 7, 15, 14, 12, 8, 0};
        run_seq("ftd", 8);

        // enable freeze mid-fill
        mode = 2'd0; dir = 0; do_reset(); en = 1;
        wait_tick(c);
        wait_tick(c);
        chk("freeze_start_q", int'(q0), 3);
        @(negedge clk);
        en = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("freeze_q", int'(q0), 3);
            chk("freeze_tick", int'(tick0), 0);
        end
        en = 1;
        wait_tick(c);
        chk("resume_latency", c, 2);
        chk("resume_q", int'(q0), 7);

        // reset mid-sequence at q=0111
        mode = 2'd0; do_reset(); en = 1;
        for (int k = 0; k < 3; k++) wait_tick(c);
        chk("pre_reset_q", int'(q0), 7);
        rs = 0;
        @(negedge clk);
        chk("midreset_q", int'(q0), 0);
        chk("midreset_tick", int'(tick0), 0);
        chk("midreset_done", int'(done0), 0);
        rs = 1;

        // mode switch in the same cycle as a pending step
        mode = 2'd0; do_reset(); en = 1;
        wait_tick(c);
        wait_tick(c);
        @(negedge clk);
        @(negedge clk);
        mode = 2'd2;
        @(negedge clk);
        chk("switch_q", int'(q0), 1);
        chk("switch_tick", int'(tick0), 0);

        // DIV=1 instance steps every enabled cycle
        mode = 2'd0; dir = 0; do_reset(); en = 1;
        repeat (3) @(negedge clk);
        chk("div1_q", int'(q1), 7);
        chk("div1_tick", int'(tick1), 1);

        // randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            rs = ($urandom % 200) != 0;
            en = ($urandom % 8) != 0;
            if ($urandom % 150 == 0) mode = 2'($urandom);
            if ($urandom % 120 == 0) dir = 1'($urandom);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
